alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised successor to the single-cycle CPU ALU. Data width is configurable.
- Adds valid/ready handshakes on input and output, registered results and flags, and an optional iterative multiply/divide unit that takes multiple cycles.
- Sits between decode/operand fetch and writeback in the CPU datapath, and decodes the 32-bit instruction word directly.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a power of 2, at least 8.
- MULDIV_EN, 1, when 1 the MUL/DIVU/REMU functions are implemented; when 0 they decode as illegal.

Ports:
- clk  in  1  system clock; rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- instruction  in  32  bits [31:26] are the opcode, bits [5:0] are the func field.
- input_data1  in  WIDTH  operand A.
- input_data2  in  WIDTH  operand B.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  downstream consumes the result.
- output_result  out  WIDTH  registered result.
- zero  out  1  registered; high when output_result == 0.
- overflow  out  1  registered signed overflow; meaningful for ADD/SUB only, 0 otherwise.
- illegal  out  1  registered; the accepted instruction did not decode.
- busy  out  1  high while an iterative operation is in progress.

Behaviour:
- Reset (synchronous, high): state=IDLE; out_valid=0; output_result=0; zero=0; overflow=0; illegal=0; busy=0; iteration counter=0. An in-flight multiply/divide is discarded without output.
- Accept: a transfer occurs on a rising edge when in_valid && in_ready.
  - in_ready = (state==IDLE) && (!out_valid || out_ready). It is combinational and low during reset.
  - Operands and instruction are captured at the accepting edge; later input changes are ignored.
- Output: out_valid and all result/flag registers are held stable until an edge with out_ready=1. out_valid clears on that edge unless a new single-cycle result is loaded on the same edge, which is allowed (back-to-back throughput of 1 per cycle).
- Decode: opcode 6'b000001 selects ALU operations by func. Any other opcode, or an unlisted func, gives result 0, illegal=1, latency 1.
- func codes:
  - 000001 ADD; 000010 SUB (A-B).
  - 000011 AND; 000100 OR; 000101 XOR.
  - 000110 SLT (signed, result 1/0); 000111 SLTU (unsigned, result 1/0).
  - 001000 SLL; 001001 SRL; 001010 SRA.
  - 001011 MUL (low WIDTH bits of A*B); 001100 DIVU (unsigned quotient); 001101 REMU (unsigned remainder).
- Shift amount = input_data2[log2(WIDTH)-1:0]; upper bits are ignored.
- overflow:
  - ADD: set when A and B have the same sign and the result sign differs.
  - SUB: set when A and B have different signs and the result sign differs from A.
  - Results wrap modulo 2^WIDTH.
- State machine:
  - IDLE: on accept of a single-cycle op, load results and set out_valid at that edge (latency 1). On accept of MUL/DIVU/REMU, go to BUSY with counter=0 and busy=1.
  - BUSY: one iteration per cycle.
    - MUL: shift-add, LSB first.
    - DIVU/REMU: restoring division, MSB first.
    - counter increments each cycle. On the edge where counter reaches WIDTH-1, load result and flags, set out_valid, clear busy, and return to IDLE.
    - out_valid therefore rises WIDTH edges after the accepting edge.
    - in_ready=0 throughout BUSY.
- BUSY is entered only when the output register is free or being consumed, so completion never overwrites an unconsumed result.
- Divide by zero (B==0): DIVU result all-ones; REMU result = A. Full iteration latency still applies; illegal=0.
- MULDIV_EN=0: func 001011/001100/001101 behave as illegal (result 0, latency 1).
- zero is computed on the final result for every operation, including illegal ones (illegal ⇒ zero=1).

Test Plan:
- Reset, then ADD, A=1, B=2 with out_ready=1 → out_valid the next cycle; output_result=3, zero=0, overflow=0. Reset asserted mid-stream → out_valid=0 on the following edge.
- ADD 7FFFFFFF+1 → 80000000, overflow=1. SUB 5-5 → 0, zero=1. SLT FFFFFFFF vs 1 → 1. SLTU same operands → 0. SRA 80000000 by 33 (amount 1) → C0000000.
- MUL 0000FFFF*00010001 → FFFFFFFF. out_valid rises exactly 32 edges after accept; busy=1 and in_ready=0 in between; a second in_valid held during busy is not accepted until IDLE.
- DIVU 100/7 → 14; REMU 100/7 → 2; DIVU x/0 → FFFFFFFF; REMU 12345678/0 → 12345678.
- Backpressure: out_ready=0 with three queued ADDs → first result held stable and in_ready=0. Release out_ready → results delivered one per cycle in order, none lost or duplicated.
- Illegal opcode 000101 and illegal func 111111 → result 0, illegal=1, zero=1. Reset asserted during BUSY MUL → no out_valid, in_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle CPU ALU with valid/ready handshakes, registered result/flags and an
// optional iterative shift-add multiplier / restoring divider.
module alu_mc #(
  parameter int WIDTH     = 32,
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  input  logic [WIDTH-1:0] input_data1,
  input  logic [WIDTH-1:0] input_data2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] output_result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic             busy
);
  localparam int SH = $clog2(WIDTH);
  localparam logic [SH-1:0] LAST = SH'(WIDTH - 1);

  localparam logic [5:0] OP_ALU = 6'b000001;
  localparam logic [5:0] F_ADD  = 6'b000001, F_SUB  = 6'b000010, F_AND = 6'b000011,
                         F_OR   = 6'b000100, F_XOR  = 6'b000101, F_SLT = 6'b000110,
                         F_SLTU = 6'b000111, F_SLL  = 6'b001000, F_SRL = 6'b001001,
                         F_SRA  = 6'b001010, F_MUL  = 6'b001011, F_DIVU = 6'b001100,
                         F_REMU = 6'b001101;

  typedef enum logic { IDLE, BUSY } state_t;
  typedef enum logic [1:0] { MD_MUL, MD_DIVU, MD_REMU } md_op_t;

  state_t            state;
  md_op_t            md_q, md_sel;
  logic [SH-1:0]     cnt;
  logic [WIDTH-1:0]  x_q, y_q, acc_q, x_n, y_n, acc_n, md_res;

  logic [5:0]        opcode, func;
  logic [WIDTH-1:0]  a, b, sum, diff, alu_res;
  logic [SH-1:0]     shamt;
  logic              alu_ovf, alu_ill, is_md, accept;
  logic              unused_instr;

  assign opcode       = instruction[31:26];
  assign func         = instruction[5:0];
  assign unused_instr = ^instruction[25:6];
  assign a            = input_data1;
  assign b            = input_data2;
  assign shamt        = b[SH-1:0];
  assign sum          = a + b;
  assign diff         = a - b;

  assign in_ready = !reset && (state == IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    is_md   = 1'b0;
    md_sel  = MD_MUL;
    if (opcode != OP_ALU) begin
      alu_ill = 1'b1;
    end else begin
      case (func)
        F_ADD: begin
          alu_res = sum;
          alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        end
        F_SUB: begin
          alu_res = diff;
          alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
        end
        F_AND:  alu_res = a & b;
        F_OR:   alu_res = a | b;
        F_XOR:  alu_res = a ^ b;
        F_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
        F_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
        F_SLL:  alu_res = a << shamt;
        F_SRL:  alu_res = a >> shamt;
        F_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
        F_MUL:  begin is_md = MULDIV_EN; alu_ill = !MULDIV_EN; md_sel = MD_MUL;  end
        F_DIVU: begin is_md = MULDIV_EN; alu_ill = !MULDIV_EN; md_sel = MD_DIVU; end
        F_REMU: begin is_md = MULDIV_EN; alu_ill = !MULDIV_EN; md_sel = MD_REMU; end
        default: alu_ill = 1'b1;
      endcase
    end
  end

  // One iteration step. MUL: x = shifted multiplicand, y = remaining multiplier bits.
  // DIVU/REMU: x = divisor, y = dividend shifting out MSB-first while quotient shifts in.
  // B==0 falls out naturally: every compare succeeds (all-ones quotient, remainder = A).
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             div_ge;
  assign rem_sh  = {acc_q, y_q[WIDTH-1]};
  assign div_ge  = rem_sh >= {1'b0, x_q};
  assign rem_sub = rem_sh[WIDTH-1:0] - x_q;

  always_comb begin
    acc_n = acc_q;
    x_n   = x_q;
    y_n   = y_q;
    if (md_q == MD_MUL) begin
      acc_n = acc_q + (y_q[0] ? x_q : '0);
      x_n   = x_q << 1;
      y_n   = y_q >> 1;
    end else begin
      acc_n = div_ge ? rem_sub : rem_sh[WIDTH-1:0];
      y_n   = {y_q[WIDTH-2:0], div_ge};
    end
    md_res = (md_q == MD_DIVU) ? y_n : acc_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      md_q          <= MD_MUL;
      cnt           <= '0;
      x_q           <= '0;
      y_q           <= '0;
      acc_q         <= '0;
      out_valid     <= 1'b0;
      output_result <= '0;
      zero          <= 1'b0;
      overflow      <= 1'b0;
      illegal       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      if (out_ready) out_valid <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (is_md) begin
            state <= BUSY;
            busy  <= 1'b1;
            cnt   <= '0;
            md_q  <= md_sel;
            x_q   <= (md_sel == MD_MUL) ? a : b;
            y_q   <= (md_sel == MD_MUL) ? b : a;
            acc_q <= '0;
          end else begin
            output_result <= alu_res;
            zero          <= (alu_res == '0);
            overflow      <= alu_ovf;
            illegal       <= alu_ill;
            out_valid     <= 1'b1;
          end
        end
      end else begin
        acc_q <= acc_n;
        x_q   <= x_n;
        y_q   <= y_n;
        if (cnt == LAST) begin
          state         <= IDLE;
          busy          <= 1'b0;
          output_result <= md_res;
          zero          <= (md_res == '0);
          overflow      <= 1'b0;
          illegal       <= 1'b0;
          out_valid     <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: directed test-plan cases plus randomized traffic, all checked
// against an arithmetic reference model and a per-cycle handshake/latency monitor.
module tb_alu_mc;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, in_valid, out_ready;
  logic          in_ready, out_valid, zero, overflow, illegal, busy;
  logic [31:0]   instruction;
  logic [W-1:0]  input_data1, input_data2, output_result;

  alu_mc #(.WIDTH(W), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .input_data1(input_data1), .input_data2(input_data2),
    .out_valid(out_valid), .out_ready(out_ready), .output_result(output_result),
    .zero(zero), .overflow(overflow), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int npass = 0, ntot = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    logic [31:0] res;
    bit          ov;
    bit          ill;
    bit          md;
    int          appear;
  } exp_t;

  // Reference model: plain arithmetic on 64-bit integers.
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
    exp_t   r;
    longint sa, sb, s;
    int     sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % 32);
    r.res = 0; r.ov = 0; r.ill = 0; r.md = 0; r.appear = 0;
    if (instr[31:26] != 6'd1) r.ill = 1;
    else case (instr[5:0])
      6'd1:  begin s = sa + sb; r.res = a + b; r.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'd2:  begin s = sa - sb; r.res = a - b; r.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'd3:  r.res = a & b;
      6'd4:  r.res = a | b;
      6'd5:  r.res = a ^ b;
      6'd6:  r.res = (sa < sb) ? 1 : 0;
      6'd7:  r.res = (a < b) ? 1 : 0;
      6'd8:  r.res = a << sh;
      6'd9:  r.res = a >> sh;
      6'd10: r.res = 32'(sa >>> sh);
      6'd11: begin r.md = 1; r.res = a * b; end
      6'd12: begin r.md = 1; r.res = (b == 0) ? 32'hFFFF_FFFF : a / b; end
      6'd13: begin r.md = 1; r.res = (b == 0) ? a : a % b; end
      default: r.ill = 1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] opc, input logic [5:0] fn);
    return {opc, 20'($urandom), fn};
  endfunction

  // Monitor: expected results queue, latency, stability, in_ready/busy each cycle.
  exp_t        q[$];
  int          busy_end = 0;
  bit          rst_prev = 0, prev_ov = 0, prev_cons = 0;
  logic [31:0] prev_res;
  logic [2:0]  prev_flags;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      q.delete();
      busy_end = 0;
      chk("rst_in_ready", in_ready, 0);
      rst_prev = 1; prev_ov = 0; prev_cons = 0;
    end else begin
      if (rst_prev) begin
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", output_result, 0);
        chk("rst_flags", {zero, overflow, illegal, busy}, 0);
      end
      chk("busy", busy, cyc < busy_end);
      chk("in_ready", in_ready, (cyc >= busy_end) && (!out_valid || out_ready));
      if (prev_ov && !prev_cons) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_result", output_result, prev_res);
        chk("hold_flags", {zero, overflow, illegal}, prev_flags);
      end
      if (out_valid && (!prev_ov || prev_cons)) begin
        if (q.size() == 0) chk("spurious_out_valid", 1, 0);
        else chk("latency", cyc, q[0].appear);
      end
      if (!out_valid && q.size() > 0 && cyc >= q[0].appear) begin
        chk("missing_result", 0, 1);
        void'(q.pop_front());
      end
      if (out_valid && out_ready && q.size() > 0) begin
        e = q.pop_front();
        chk("result", output_result, e.res);
        chk("zero", zero, e.res == 0);
        chk("overflow", overflow, e.ov);
        chk("illegal", illegal, e.ill);
      end
      if (in_valid && in_ready) begin
        e = model(instruction, input_data1, input_data2);
        e.appear = cyc + 1 + (e.md ? W : 0);
        if (e.md) busy_end = cyc + 1 + W;
        q.push_back(e);
      end
      prev_ov    = out_valid;
      prev_cons  = out_valid && out_ready;
      prev_res   = output_result;
      prev_flags = {zero, overflow, illegal};
      rst_prev   = 0;
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    bit got = 0;
    in_valid = 1; instruction = ins; input_data1 = a; input_data2 = b;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk); #1;
      if (got) break;
    end
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic run_op(input string nm, input logic [5:0] opc, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] er,
                        input bit eov, input bit eill, input int lat);
    bit found = 0;
    int t;
    out_ready = 1;
    send(mk(opc, fn), a, b);
    in_valid = 0;
    t = cyc;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (out_valid) begin found = 1; break; end
    end
    chk({nm, "_seen"}, found, 1);
    chk({nm, "_lat"}, cyc - t, lat);
    chk({nm, "_res"}, output_result, er);
    chk({nm, "_flags"}, {zero, overflow, illegal}, {er == 0, eov, eill});
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(5))
      0: return 0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(40);
      default: return $urandom;
    endcase
  endfunction

  bit rnd_done = 0;

  initial begin
    exp_t e;
    int   t1, seen;
    reset = 1; in_valid = 0; out_ready = 1;
    instruction = 0; input_data1 = 0; input_data2 = 0;

    // Pin the model to hand-computed values.
    e = model(mk(1, 1), 32'h7FFF_FFFF, 1);            chk("pin_add", {e.res, 31'b0, e.ov}, {32'h8000_0000, 32'h1});
    e = model(mk(1, 10), 32'h8000_0000, 33);          chk("pin_sra", e.res, 32'hC000_0000);
    e = model(mk(1, 6), 32'hFFFF_FFFF, 1);            chk("pin_slt", e.res, 1);
    e = model(mk(1, 13), 100, 7);                     chk("pin_remu", e.res, 2);
    e = model(mk(1, 2), 32'h8000_0000, 1);            chk("pin_sub_ov", e.ov, 1);

    repeat (3) @(posedge clk);
    #1 reset = 0;

    run_op("add", 1, 1, 1, 2, 3, 0, 0, 0);

    // Reset while a result is held.
    out_ready = 0;
    send(mk(1, 1), 5, 6);
    in_valid = 0;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk); chk("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1;

    run_op("add_ovf", 1, 1, 32'h7FFF_FFFF, 1, 32'h8000_0000, 1, 0, 0);
    run_op("sub_zero", 1, 2, 5, 5, 0, 0, 0, 0);
    run_op("slt", 1, 6, 32'hFFFF_FFFF, 1, 1, 0, 0, 0);
    run_op("sltu", 1, 7, 32'hFFFF_FFFF, 1, 0, 0, 0, 0);
    run_op("sra", 1, 10, 32'h8000_0000, 33, 32'hC000_0000, 0, 0, 0);
    run_op("mul", 1, 11, 32'h0000_FFFF, 32'h0001_0001, 32'hFFFF_FFFF, 0, 0, W);
    run_op("divu", 1, 12, 100, 7, 14, 0, 0, W);
    run_op("remu", 1, 13, 100, 7, 2, 0, 0, W);
    run_op("divu0", 1, 12, 32'hDEAD_BEEF, 0, 32'hFFFF_FFFF, 0, 0, W);
    run_op("remu0", 1, 13, 32'h1234_5678, 0, 32'h1234_5678, 0, 0, W);
    run_op("ill_op", 6'b000101, 1, 3, 4, 0, 0, 1, 0);
    run_op("ill_fn", 1, 6'b111111, 3, 4, 0, 0, 1, 0);

    // A request held during BUSY waits for completion.
    send(mk(1, 11), 7, 9);
    t1 = cyc;
    send(mk(1, 1), 1, 1);
    in_valid = 0;
    chk("held_during_busy", cyc - t1, W + 1);
    repeat (3) @(posedge clk); #1;

    // Backpressure with three queued ADDs.
    out_ready = 0;
    fork
      begin
        send(mk(1, 1), 10, 1);
        send(mk(1, 1), 20, 2);
        send(mk(1, 1), 30, 3);
        in_valid = 0;
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    repeat (3) @(posedge clk); #1;

    // Reset during a BUSY multiply discards it.
    send(mk(1, 11), 32'h1234, 32'h5678);
    in_valid = 0;
    repeat (5) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    @(negedge clk); chk("busyrst_in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("busyrst_no_output", seen, 0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure.
    fork
      while (!rnd_done) begin
        @(posedge clk); #1 out_ready = ($urandom_range(3) != 0);
      end
    join_none
    for (int n = 0; n < 300; n++) begin
      logic [5:0] opc, fn;
      opc = ($urandom_range(9) == 0) ? 6'($urandom) : 6'd1;
      fn  = 6'($urandom_range(15));
      send(mk(opc, fn), rnd_val(), rnd_val());
      if ($urandom_range(3) == 0) begin
        in_valid = 0;
        repeat ($urandom_range(3)) @(posedge clk);
        #1;
      end
    end
    in_valid = 0;
    rnd_done = 1;
    @(posedge clk); #2 out_ready = 1;
    repeat (W + 5) @(posedge clk);
    @(negedge clk);
    chk("drained", q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
